// File: rtl/connect4_key_cursor_if.sv
// Keyboard-side bus of the Connect-4 drop cursor: raw frame clock and keycode in,
// cursor position and drop request handshake out.
interface connect4_key_cursor_if;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       drop_ack;
  logic [2:0] cursor_col;
  logic [9:0] cursor_x;
  logic       drop_req;
  logic [2:0] drop_col;

  modport master (
    output frame_clk,
    output keycode,
    output drop_ack,
    input  cursor_col,
    input  cursor_x,
    input  drop_req,
    input  drop_col
  );

  modport slave (
    input  frame_clk,
    input  keycode,
    input  drop_ack,
    output cursor_col,
    output cursor_x,
    output drop_req,
    output drop_col
  );
endinterface

// File: rtl/connect4_key_cursor.sv
// HID keycode to drop-column cursor: press-edge stepping with frame-tick auto-repeat,
// plus a req/ack drop handshake that freezes the cursor while a drop is pending.
module connect4_key_cursor #(
  parameter int         NUM_COLS     = 7,
  parameter int         START_COL    = 3,
  parameter int         COL_X0       = 128,
  parameter int         COL_PITCH    = 64,
  parameter int         REPEAT_DELAY = 20,
  parameter int         REPEAT_RATE  = 6,
  parameter logic [7:0] KEY_LEFT     = 8'h04,
  parameter logic [7:0] KEY_RIGHT    = 8'h07,
  parameter logic [7:0] KEY_DROP     = 8'h2C
) (
  input  logic                  Clk,
  input  logic                  Reset,
  connect4_key_cursor_if.slave  bus
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0]       COL_MAX    = 3'(NUM_COLS - 1);
  localparam logic [2:0]       COL_START  = 3'(START_COL);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DELAY  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] CNT_RATE   = CNT_W'(REPEAT_RATE);

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_LEFT  = 2'd1,
    CLS_RIGHT = 2'd2,
    CLS_DROP  = 2'd3
  } key_cls_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } drop_st_t;

  function automatic key_cls_t classify(input logic [7:0] code);
    key_cls_t cls;
    case (code)
      KEY_LEFT:  cls = CLS_LEFT;
      KEY_RIGHT: cls = CLS_RIGHT;
      KEY_DROP:  cls = CLS_DROP;
      default:   cls = CLS_NONE;
    endcase
    return cls;
  endfunction

  // Registered state
  logic             fs1_q, fs2_q, fs3_q;
  key_cls_t         prev_cls_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cursor_col_q, cursor_col_d;
  drop_st_t         state_q, state_d;
  logic             drop_req_q, drop_req_d;
  logic [2:0]       drop_col_q, drop_col_d;

  // Combinational decode
  key_cls_t key_cls_s;
  logic     frame_tick_s;
  logic     press_s;
  logic     lr_s;
  logic     step_s;

  assign key_cls_s    = classify(bus.keycode);
  assign frame_tick_s = fs2_q & ~fs3_q;
  assign press_s      = (key_cls_s != CLS_NONE) && (key_cls_s != prev_cls_q);
  assign lr_s         = (key_cls_s == CLS_LEFT) || (key_cls_s == CLS_RIGHT);

  // Repeat counter runs regardless of the drop FSM; only the cursor step is gated by it.
  always_comb begin
    cnt_d  = cnt_q;
    step_s = 1'b0;
    if (!lr_s) begin
      cnt_d = CNT_ZERO;
    end else if (press_s) begin
      cnt_d  = CNT_DELAY;
      step_s = 1'b1;
    end else if (frame_tick_s) begin
      if (cnt_q == CNT_ONE) begin
        cnt_d  = CNT_RATE;
        step_s = 1'b1;
      end else if (cnt_q != CNT_ZERO) begin
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Saturating cursor step, frozen while a drop is pending
  always_comb begin
    cursor_col_d = cursor_col_q;
    if (step_s && (state_q == ST_IDLE)) begin
      if (key_cls_s == CLS_LEFT) begin
        if (cursor_col_q == 3'd0) begin
          cursor_col_d = 3'd0;
        end else begin
          cursor_col_d = cursor_col_q - 3'd1;
        end
      end else begin
        if (cursor_col_q >= COL_MAX) begin
          cursor_col_d = COL_MAX;
        end else begin
          cursor_col_d = cursor_col_q + 3'd1;
        end
      end
    end else begin
      cursor_col_d = cursor_col_q;
    end
  end

  // Drop request FSM next state
  always_comb begin
    state_d    = state_q;
    drop_req_d = drop_req_q;
    drop_col_d = drop_col_q;
    case (state_q)
      ST_IDLE: begin
        if (press_s && (key_cls_s == CLS_DROP)) begin
          state_d    = ST_REQ;
          drop_req_d = 1'b1;
          drop_col_d = cursor_col_q;
        end else begin
          state_d    = ST_IDLE;
          drop_req_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (bus.drop_ack) begin
          state_d    = ST_IDLE;
          drop_req_d = 1'b0;
        end else begin
          state_d    = ST_REQ;
          drop_req_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        drop_req_d = 1'b0;
      end
    endcase
  end

  // All state, including the frame_clk synchroniser and its edge-detect flop
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fs1_q        <= 1'b0;
      fs2_q        <= 1'b0;
      fs3_q        <= 1'b0;
      prev_cls_q   <= CLS_NONE;
      cnt_q        <= CNT_ZERO;
      cursor_col_q <= COL_START;
      state_q      <= ST_IDLE;
      drop_req_q   <= 1'b0;
      drop_col_q   <= COL_START;
    end else begin
      fs1_q        <= bus.frame_clk;
      fs2_q        <= fs1_q;
      fs3_q        <= fs2_q;
      prev_cls_q   <= key_cls_s;
      cnt_q        <= cnt_d;
      cursor_col_q <= cursor_col_d;
      state_q      <= state_d;
      drop_req_q   <= drop_req_d;
      drop_col_q   <= drop_col_d;
    end
  end

  assign bus.cursor_col = cursor_col_q;
  assign bus.cursor_x   = 10'(COL_X0) + (10'(cursor_col_q) * 10'(COL_PITCH));
  assign bus.drop_req   = drop_req_q;
  assign bus.drop_col   = drop_col_q;

endmodule

// File: tb/tb_connect4_key_cursor.sv
// Randomised and directed bench for connect4_key_cursor against a tick-counting model.
module tb_connect4_key_cursor;
  localparam int NUM_COLS     = 7;
  localparam int START_COL    = 3;
  localparam int COL_X0       = 128;
  localparam int COL_PITCH    = 64;
  localparam int REPEAT_DELAY = 20;
  localparam int REPEAT_RATE  = 6;

  logic Clk = 1'b0;
  logic Reset;
  connect4_key_cursor_if bus();

  connect4_key_cursor dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // 0 none, 1 left, 2 right, 3 drop
  function automatic int classify(logic [7:0] k);
    if (k == 8'h04) return 1;
    if (k == 8'h07) return 2;
    if (k == 8'h2C) return 3;
    return 0;
  endfunction

  // Behavioural model: counts frame ticks since the last LEFT/RIGHT press
  int m_col, m_dcol, m_prev, held_ticks, edge_n;
  bit m_req, last_fc, m_valid;
  int tickq[$];

  always @(posedge Clk) begin
    int  cls;
    bit  press, tick, step;
    if (Reset) begin
      m_col = START_COL; m_dcol = START_COL; m_req = 1'b0; m_prev = 0;
      held_ticks = 0; last_fc = 1'b0; tickq.delete();
    end else begin
      edge_n++;
      cls   = classify(bus.keycode);
      press = (cls != 0) && (cls != m_prev);
      tick  = 1'b0;
      if (tickq.size() > 0 && tickq[0] == edge_n) begin
        tick = 1'b1;
        void'(tickq.pop_front());
      end
      if (bus.frame_clk && !last_fc) tickq.push_back(edge_n + 2);
      last_fc = bus.frame_clk;
      step = 1'b0;
      if (cls == 1 || cls == 2) begin
        if (press) begin
          held_ticks = 0;
          step = 1'b1;
        end else if (tick) begin
          held_ticks++;
          if (held_ticks >= REPEAT_DELAY && ((held_ticks - REPEAT_DELAY) % REPEAT_RATE) == 0)
            step = 1'b1;
        end
      end else begin
        held_ticks = 0;
      end
      if (!m_req) begin
        if (step) begin
          if (cls == 1) m_col = (m_col > 0) ? m_col - 1 : 0;
          else          m_col = (m_col < NUM_COLS - 1) ? m_col + 1 : NUM_COLS - 1;
        end
        if (press && cls == 3) begin
          m_req  = 1'b1;
          m_dcol = m_col;
        end
      end else if (bus.drop_ack) begin
        m_req = 1'b0;
      end
      m_prev = cls;
    end
    m_valid = 1'b1;
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge Clk) begin
    if (m_valid) begin
      chk("cursor_col", int'(bus.cursor_col), m_col);
      chk("cursor_x",   int'(bus.cursor_x),   COL_X0 + m_col * COL_PITCH);
      chk("drop_req",   int'(bus.drop_req),   int'(m_req));
      chk("drop_col",   int'(bus.drop_col),   m_dcol);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic tap(logic [7:0] k);
    bus.keycode = k;
    cyc(1);
    bus.keycode = 8'h00;
    cyc(1);
  endtask

  task automatic fpulse(int gap);
    bus.frame_clk = 1'b1;
    cyc(gap / 2);
    bus.frame_clk = 1'b0;
    cyc(gap / 2);
  endtask

  // Hand-computed expectation applied to both DUT and model
  task automatic pin_col(string name, int exp);
    chk({name, "_dut"},   int'(bus.cursor_col), exp);
    chk({name, "_x"},     int'(bus.cursor_x), COL_X0 + exp * COL_PITCH);
    chk({name, "_model"}, m_col, exp);
  endtask

  task automatic pin_req(string name, int exp_req, int exp_col);
    chk({name, "_req"},   int'(bus.drop_req), exp_req);
    chk({name, "_model"}, int'(m_req), exp_req);
    if (exp_req != 0) chk({name, "_col"}, int'(bus.drop_col), exp_col);
  endtask

  logic [7:0] codes [6];

  initial begin
    codes = '{8'h00, 8'h04, 8'h07, 8'h2C, 8'h1A, 8'h00};
    Reset = 1'b1;
    bus.keycode = 8'h00;
    bus.frame_clk = 1'b0;
    bus.drop_ack = 1'b0;
    cyc(3);
    Reset = 1'b0;
    cyc(1);
    pin_col("reset", 3);
    pin_req("reset", 0, 3);

    tap(8'h04);
    pin_col("tap_left", 2);
    cyc(3);
    pin_col("tap_left_hold", 2);

    repeat (5) tap(8'h07);
    pin_col("sat_right", 6);
    repeat (8) tap(8'h04);
    pin_col("sat_left", 0);

    bus.keycode = 8'h07;
    cyc(1);
    pin_col("rep_press", 1);
    repeat (19) fpulse(100);
    pin_col("rep_t19", 1);
    fpulse(100);
    pin_col("rep_t20", 2);
    repeat (5) fpulse(100);
    pin_col("rep_t25", 2);
    fpulse(100);
    pin_col("rep_t26", 3);
    repeat (6) fpulse(100);
    pin_col("rep_t32", 4);
    bus.keycode = 8'h00;
    repeat (3) fpulse(100);
    pin_col("rep_release", 4);

    bus.keycode = 8'h2C;
    cyc(1);
    pin_req("drop", 1, 4);
    bus.keycode = 8'h04;
    cyc(2);
    pin_col("drop_frozen", 4);
    bus.keycode = 8'h2C;
    cyc(2);
    bus.drop_ack = 1'b1;
    cyc(1);
    bus.drop_ack = 1'b0;
    pin_req("drop_acked", 0, 0);
    cyc(4);
    pin_req("drop_no_rereq", 0, 0);
    bus.keycode = 8'h00;
    cyc(2);

    bus.keycode = 8'h07;
    cyc(1);
    pin_col("coin_press", 5);
    repeat (19) fpulse(20);
    pin_col("coin_t19", 5);
    bus.frame_clk = 1'b1;
    cyc(2);
    bus.keycode = 8'h04;
    cyc(1);
    pin_col("coin_edge", 4);
    bus.frame_clk = 1'b0;
    bus.keycode = 8'h00;
    cyc(5);
    pin_col("coin_after", 4);

    bus.keycode = 8'h2C;
    cyc(1);
    pin_req("rst_req", 1, 4);
    bus.keycode = 8'h00;
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    pin_req("rst_drop", 0, 0);
    pin_col("rst_col", 3);

    bus.keycode = 8'h04;
    cyc(1);
    pin_col("lr_left", 2);
    bus.keycode = 8'h07;
    cyc(1);
    pin_col("lr_right", 3);
    bus.keycode = 8'h1A;
    cyc(3);
    pin_col("unmapped", 3);
    bus.keycode = 8'h00;
    cyc(2);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 9) == 0) bus.keycode = 8'($urandom);
        else bus.keycode = codes[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 3) == 0) bus.frame_clk = ~bus.frame_clk;
      bus.drop_ack = ($urandom_range(0, 3) == 0);
      Reset = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    Reset = 1'b0;
    bus.drop_ack = 1'b0;
    bus.keycode = 8'h00;
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
